// File: rtl/fpu_accum16.sv
// Accumulates a valid/ready stream of fp16 operands through an external
// combinational fp16 add/sub unit; one element every two cycles.
module fpu_accum16 #(
   parameter int MAX_LEN = 16,
   parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
   input  logic             clock,
   input  logic             reset_L,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic [15:0]      init,
   input  logic             inValid,
   output logic             inReady,
   input  logic [15:0]      inData,
   input  logic             inSub,
   output logic [15:0]      addIn1,
   output logic [15:0]      addIn2,
   output logic             addSub,
   input  logic [15:0]      addOut,
   input  logic [3:0]       addCC,
   input  logic [4:0]       addFlags,
   output logic             busy,
   output logic             outValid,
   input  logic             outReady,
   output logic [15:0]      result,
   output logic [3:0]       resultCC,
   output logic [4:0]       resultFlags
);

   typedef enum logic [1:0] {IDLE, WAIT, EXEC, DONE} state_t;

   state_t           state_reg, state_next;
   logic [15:0]      acc_reg;
   logic [15:0]      op_reg;
   logic             sub_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [3:0]       cc_reg;
   logic [4:0]       flags_reg;
   logic [CNT_W-1:0] len_clamp;

   assign len_clamp = (len > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : len;

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (start) state_next = (len_clamp != '0) ? WAIT : DONE;
         WAIT: if (inValid) state_next = EXEC;
         EXEC: state_next = (cnt_reg == CNT_W'(1)) ? DONE : WAIT;
         DONE: if (outReady) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Condition codes on start describe the initial value, so a len=0 run reports sensible ZCNV.
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         acc_reg   <= '0;
         op_reg    <= '0;
         sub_reg   <= 1'b0;
         cnt_reg   <= '0;
         cc_reg    <= '0;
         flags_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: if (start) begin
               acc_reg   <= init;
               cnt_reg   <= len_clamp;
               flags_reg <= '0;
               op_reg    <= '0;
               sub_reg   <= 1'b0;
               cc_reg    <= {init[14:0] == 15'd0, 1'b0, init[15], 1'b0};
            end
            WAIT: if (inValid) begin
               op_reg  <= inData;
               sub_reg <= inSub;
            end
            EXEC: begin
               acc_reg   <= addOut;
               cc_reg    <= addCC;
               flags_reg <= flags_reg | addFlags;
               cnt_reg   <= cnt_reg - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign inReady     = (state_reg == WAIT);
   assign outValid    = (state_reg == DONE);
   assign busy        = (state_reg != IDLE);
   assign addIn1      = acc_reg;
   assign addIn2      = op_reg;
   assign addSub      = sub_reg;
   assign result      = acc_reg;
   assign resultCC    = cc_reg;
   assign resultFlags = flags_reg;

endmodule
